// File: rtl/pe_lin_drain.sv
// Drain stage for the linear PE array. Each lane accumulates ACC_LEN samples with saturation.
// Finished vectors queue in a small FIFO and leave one lane per beat on a valid/ready stream.
module pe_lin_drain #(
    parameter int N_PE    = 4,
    parameter int OW      = 12,
    parameter int ACC_W   = 16,
    parameter int ACC_LEN = 4,
    parameter int DEPTH   = 4,
    parameter int LW      = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N_PE*OW-1:0] in_outs,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [LW-1:0]      out_lane,
    output logic               out_last,
    output logic               sat_flag
);
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ACC_LEN - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(N_PE - 1);
    localparam logic [NW-1:0] CNT_FULL  = NW'(DEPTH);

    typedef logic [N_PE-1:0][ACC_W-1:0] vec_t;

    vec_t          acc_q, acc_d;
    vec_t          acc_sum;
    vec_t          acc_new;
    logic [N_PE-1:0] ovf;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          sat_q, sat_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [LW-1:0] lane_q, lane_d;
    vec_t          fifo_mem_q [DEPTH];
    vec_t          head;

    logic fifo_full, fifo_empty, accept, close, beat, pop;

    // One extra sum bit per lane exposes the overflow that triggers clamping.
    genvar gi;
    for (gi = 0; gi < N_PE; gi++) begin : g_lane
        logic [ACC_W:0] sum;
        assign sum         = {1'b0, acc_q[gi]} + {{(ACC_W + 1 - OW){1'b0}}, in_outs[gi*OW +: OW]};
        assign ovf[gi]     = sum[ACC_W];
        assign acc_sum[gi] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    always_comb begin
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        accept     = in_valid && !fifo_full;
        acc_new    = accept ? acc_sum : acc_q;

        // A held flush can only fire once the FIFO has room for the partial vector.
        close = !fifo_full &&
                ((accept && (cnt_q == CNT_LAST)) ||
                 ((flush || flush_pend_q) && (accept || (cnt_q != '0))));

        acc_d = close ? '0 : acc_new;

        cnt_d = cnt_q;
        if (close) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        flush_pend_d = flush_pend_q;
        if (close) begin
            flush_pend_d = 1'b0;
        end else if (fifo_full && flush && (cnt_q != '0)) begin
            flush_pend_d = 1'b1;
        end

        sat_d = sat_q || (accept && (|ovf));

        beat   = !fifo_empty && out_ready;
        pop    = beat && (lane_q == LANE_LAST);
        lane_d = lane_q;
        if (beat) begin
            lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q + PW'(close);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + NW'(close) - NW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            sat_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lane_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            sat_q        <= sat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lane_q       <= lane_d;
        end
    end

    always_ff @(posedge clk) begin
        if (close && !rst) begin
            fifo_mem_q[wr_ptr_q] <= acc_new;
        end
    end

    assign head      = fifo_mem_q[rd_ptr_q];
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    // Gate the data so stale FIFO contents never show while the stream is idle.
    assign out_data  = fifo_empty ? '0 : head[lane_q];
    assign out_lane  = lane_q;
    assign out_last  = (lane_q == LANE_LAST);
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_pe_lin_drain.sv
// Directed bench for pe_lin_drain: a vector-queue reference model is checked every cycle,
// and hand-computed expectations check the captured output stream after each scenario.
module tb_pe_lin_drain;
    localparam int N_PE    = 4;
    localparam int OW      = 12;
    localparam int ACC_W   = 12;
    localparam int ACC_LEN = 4;
    localparam int DEPTH   = 4;
    localparam int LW      = 2;
    localparam int MAXV    = (1 << ACC_W) - 1;

    typedef logic [N_PE-1:0][ACC_W-1:0] vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [N_PE*OW-1:0] in_outs = '0;
    logic               flush = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready, out_valid, out_last, sat_flag;
    logic [ACC_W-1:0]   out_data;
    logic [LW-1:0]      out_lane;

    int checks = 0;
    int errors = 0;
    bit live = 0;

    vec_t mq[$];
    int   m_acc[N_PE];
    int   m_n = 0;
    int   m_lane = 0;
    bit   m_pend = 0;
    bit   m_sat = 0;

    int cap_d[$];
    int cap_l[$];
    int cap_t[$];

    always #5 clk = ~clk;

    pe_lin_drain #(.N_PE(N_PE), .OW(OW), .ACC_W(ACC_W), .ACC_LEN(ACC_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_outs(in_outs), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .sat_flag(sat_flag)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N_PE*OW-1:0] lanes(input int a, input int b, input int c, input int d);
        return {OW'(d), OW'(c), OW'(b), OW'(a)};
    endfunction

    // Reference: samples summed per lane, vectors kept as a queue, one lane per accepted beat.
    task automatic model_step();
        bit   full;
        bit   popv;
        vec_t v;
        int   s;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < N_PE; k++) m_acc[k] = 0;
            m_n = 0; m_lane = 0; m_pend = 0; m_sat = 0;
        end else begin
            full = (mq.size() == DEPTH);
            popv = 0;
            if (mq.size() != 0 && out_ready) begin
                if (m_lane == N_PE - 1) begin
                    m_lane = 0;
                    popv = 1;
                end else begin
                    m_lane++;
                end
            end
            if (in_valid && !full) begin
                for (int k = 0; k < N_PE; k++) begin
                    s = m_acc[k] + int'(in_outs[k*OW +: OW]);
                    if (s > MAXV) begin
                        s = MAXV;
                        m_sat = 1;
                    end
                    m_acc[k] = s;
                end
                m_n++;
            end
            if (popv) void'(mq.pop_front());
            if (!full && (m_n == ACC_LEN || ((flush || m_pend) && m_n > 0))) begin
                for (int k = 0; k < N_PE; k++) begin
                    v[k] = ACC_W'(m_acc[k]);
                    m_acc[k] = 0;
                end
                mq.push_back(v);
                m_n = 0;
                m_pend = 0;
            end else if (full && flush && m_n > 0) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic compare_step();
        vec_t h;
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("sat_flag", sat_flag, m_sat);
        chk("out_lane", out_lane, m_lane);
        chk("out_last", out_last, m_lane == N_PE - 1);
        if (mq.size() != 0) begin
            h = mq[0];
            chk("out_data", out_data, h[m_lane]);
        end else begin
            chk("out_data_idle", out_data, 0);
        end
        if (out_valid && out_ready && !rst) begin
            $display("txn t=%0t lane=%0d data=%0d last=%0d", $time, out_lane, out_data, out_last);
            cap_d.push_back(out_data);
            cap_l.push_back(out_lane);
            cap_t.push_back(out_last);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (live) compare_step();
    end

    task automatic drive(input logic [N_PE*OW-1:0] d, input logic v, input logic f);
        in_outs = d;
        in_valid = v;
        flush = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cap_clear();
        cap_d.delete();
        cap_l.delete();
        cap_t.delete();
    endtask

    task automatic check_stream(input string nm, input int e[$]);
        chk({nm, "_count"}, cap_d.size(), e.size());
        for (int i = 0; i < e.size() && i < cap_d.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), cap_d[i], e[i]);
            chk($sformatf("%s_lane%0d", nm, i), cap_l[i], i % N_PE);
            chk($sformatf("%s_last%0d", nm, i), cap_t[i], (i % N_PE) == N_PE - 1);
        end
        cap_clear();
    endtask

    initial begin
        int e[$];

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        live = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic vector and one-cycle latency
        out_ready = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            if (a == 4) chk("basic_pre_valid", out_valid, 0);
            drive(lanes(0, a, 2 * a, 3 * a), 1'b1, 1'b0);
        end
        chk("basic_latency", out_valid, 1);
        chk("basic_first", out_data, 0);
        idle(6);
        e = '{0, 10, 20, 30};
        check_stream("basic", e);

        // Backpressure: five vectors offered, four fit
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++)
            repeat (4) drive(lanes(v, v + 1, v + 2, v + 3), 1'b1, 1'b0);
        chk("bp_full", in_ready, 0);
        repeat (4) drive(lanes(9, 9, 9, 9), 1'b1, 1'b0);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_data", out_data, 4);
        chk("bp_hold_lane", out_lane, 0);
        out_ready = 1'b1;
        idle(20);
        chk("bp_drained_ready", in_ready, 1);
        chk("bp_drained_valid", out_valid, 0);
        e.delete();
        for (int v = 1; v <= 4; v++)
            for (int k = 0; k < N_PE; k++) e.push_back(4 * (v + k));
        check_stream("bp", e);

        // Flush: partial, full after restart, flush with sample, flush on empty count
        repeat (2) drive(lanes(1, 2, 3, 4), 1'b1, 1'b0);
        drive('0, 1'b0, 1'b1);
        repeat (4) drive(lanes(1, 1, 1, 1), 1'b1, 1'b0);
        drive(lanes(5, 5, 5, 5), 1'b1, 1'b1);
        drive('0, 1'b0, 1'b1);
        idle(14);
        chk("flush_idle", out_valid, 0);
        e = '{2, 4, 6, 8, 4, 4, 4, 4, 5, 5, 5, 5};
        check_stream("flush", e);

        // Saturation and sticky flag
        repeat (20) drive(lanes(4095, 4095, 4095, 4095), 1'b1, 1'b0);
        chk("sat_set", sat_flag, 1);
        repeat (4) drive(lanes(1, 2, 3, 4), 1'b1, 1'b0);
        idle(8);
        chk("sat_sticky", sat_flag, 1);
        e.delete();
        repeat (20) e.push_back(4095);
        e.push_back(4); e.push_back(8); e.push_back(12); e.push_back(16);
        check_stream("sat", e);

        // Reset mid-serialization with two vectors queued
        out_ready = 1'b0;
        repeat (8) drive(lanes(3, 3, 3, 3), 1'b1, 1'b0);
        out_ready = 1'b1;
        idle(1);
        chk("mid_lane", out_lane, 1);
        rst = 1'b1;
        out_ready = 1'b0;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_lane", out_lane, 0);
        cap_clear();
        out_ready = 1'b1;
        repeat (4) drive(lanes(2, 2, 2, 2), 1'b1, 1'b0);
        idle(6);
        e = '{8, 8, 8, 8};
        check_stream("mid", e);

        // Push and pop on the same edge at DEPTH-1
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++)
            repeat (4) drive(lanes(16 * v, 16 * v + 1, 16 * v + 2, 16 * v + 3), 1'b1, 1'b0);
        repeat (3) drive(lanes(64, 65, 66, 67), 1'b1, 1'b0);
        out_ready = 1'b1;
        idle(3);
        chk("cc_lane3", out_lane, 3);
        chk("cc_data3", out_data, 76);
        drive(lanes(64, 65, 66, 67), 1'b1, 1'b0);
        chk("cc_ready", in_ready, 1);
        chk("cc_next_lane", out_lane, 0);
        chk("cc_next_data", out_data, 128);
        idle(16);
        chk("cc_end_valid", out_valid, 0);
        e.delete();
        for (int v = 1; v <= 4; v++)
            for (int k = 0; k < N_PE; k++) e.push_back(64 * v + 4 * k);
        check_stream("cc", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_lin_drain.md
Name: pe_lin_drain

Overview:
- Output drain stage directly downstream of the PE_Lin_gen linear PE array.
- Each accepted cycle it takes the array's N_PE parallel OW-bit results and accumulates them per lane over ACC_LEN samples, with saturation.
- Completed vectors are buffered in a small vector FIFO.
- Vectors are serialized lane-by-lane onto a valid/ready stream for writeback.

Parameters:
- N_PE, 4, number of PE lanes (matches array width).
- OW, 12, width of each PE result.
- ACC_W, 16, per-lane accumulator and output data width (ACC_W >= OW).
- ACC_LEN, 4, samples summed per output vector (>= 1).
- DEPTH, 4, vector FIFO depth in vectors (power of 2, >= 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_outs holds a valid array result this cycle (driven from the array's fire-aligned output).
- in_outs  in  N_PE x OW  per-lane PE results, unsigned.
- in_ready  out  1  drain can accept a sample; upstream must drop fire while low.
- flush  in  1  single-cycle pulse; closes a partial accumulation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  ACC_W  accumulated lane value.
- out_lane  out  clog2(N_PE)  lane index of out_data.
- out_last  out  1  high on the final lane (N_PE-1) of a vector.
- sat_flag  out  1  sticky: some accumulation saturated since reset.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears accumulators, sample counter, FIFO pointers and count, lane counter, sat_flag.
  - Next cycle: out_valid=0, out_data=0, out_lane=0, out_last=0, sat_flag=0, in_ready=1.
  - Reset mid-vector or mid-serialization discards all in-flight data.
- Accept:
  - sample accepted when in_valid & in_ready at an edge.
  - in_ready = !fifo_full, purely combinational from registered FIFO count.
  - A pop in the same cycle does not raise in_ready.
  - in_valid while in_ready=0 is ignored (no state change).
- Accumulate:
  - Per lane, sum = acc[k] + zero-extended in_outs[k], computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W-1, clamp to 2^ACC_W-1 and set sat_flag.
  - Sample counter cnt runs 0..ACC_LEN-1.
- Vector close:
  - An accepted sample with cnt==ACC_LEN-1 closes the vector.
  - At that edge the summed vector (including that sample) is written to the FIFO, accumulators clear to 0, and cnt returns to 0.
- Flush:
  - flush with cnt>0, or flush coinciding with an accepted sample, closes the vector at that edge.
  - The accepted sample is included; the partial sum is written to the FIFO.
  - flush with cnt==0 and no accepted sample is a no-op.
  - flush while FIFO full and cnt>0 is held pending and executes at the first edge where the FIFO is not full.
- Latency: out_valid rises in the cycle after the closing edge when the FIFO was empty (1 cycle).
- Serializer:
  - out_valid = !fifo_empty.
  - out_data = head[lane_cnt]; out_lane = lane_cnt; out_last = (lane_cnt==N_PE-1).
  - On out_valid & out_ready, lane_cnt increments.
  - At lane N_PE-1, lane_cnt wraps to 0 and the FIFO head pops.
  - out_* hold stable while out_valid & !out_ready.
- Simultaneous push and pop: both take effect; count unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count ranges 0..DEPTH.
- No data loss is permitted while upstream honours in_ready.

Test Plan:
- Basic: rst high 2 cycles, then ACC_LEN=4 samples with in_outs lane k = k*a for a=1..4, out_ready=1 -> out_data 0,10,20,30 on lanes 0..3; out_last only on lane 3; out_valid rises 1 cycle after the 4th sample.
- Backpressure: out_ready=0, stream 5 full vectors with DEPTH=4 -> in_ready drops after the 4th vector closes; 5th-vector samples are not accepted; after out_ready=1 all 4 vectors drain in order, then in_ready=1.
- Saturation: in_outs all 4095 for 20 samples, ACC_W=12, ACC_LEN=4 -> each lane outputs 4095; sat_flag=1 and stays 1 after further normal traffic until rst.
- Flush: 2 samples of lane values 1,2,3,4, then flush -> vector 2,4,6,8 emitted; cnt restarts so the next 4 samples form a full vector; flush with cnt==0 -> no output.
- Reset mid-op: rst asserted during lane 1 of a vector with 2 vectors queued -> next cycle out_valid=0, sat_flag=0, in_ready=1; the next full vector emits from lane 0 with fresh sums.
- Concurrent push/pop: FIFO at DEPTH-1, vector closes on the same edge as a head pop -> count stays DEPTH-1 and output order is preserved.
